// File: rtl/scope_pkg.sv
// Shared constants for the scope acquisition path: state encoding and default geometry
// matching the display's shift-register length (columns) and count (channels).
package scope_pkg;
    localparam int DEPTH_DEF = 64;
    localparam int DW_DEF    = 6;
    localparam int DIV_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;
endpackage

// File: rtl/scope_rate_div.sv
// Sample-rate divider: strobe when the counter matches div, period div+1 cycles.
// Combinational strobe; counter held at 0 while disabled or cleared.
module scope_rate_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             strobe
);
    logic [DIV_W-1:0] cnt;

    assign strobe = en && !clr && (cnt == div);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en || strobe) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/scope_sampler.sv
// Captures DEPTH samples (optionally after an edge trigger) then drains them over valid/ready.
// out_valid rises one cycle after entering DRAIN; out_data/out_valid hold while out_ready is low.
module scope_sampler
    import scope_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    sample_in,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_trig_en,
    input  logic             cfg_trig_fall,
    input  logic [2:0]       cfg_trig_bit,
    input  logic             arm,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [1:0]       state,
    output logic             done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t          st, st_nxt;
    logic [AW-1:0]   wptr, rptr, wr_addr;
    logic [DW-1:0]   prev;
    logic [DW-1:0]   buf_mem [DEPTH];
    logic            prev_vld, strobe, trig_hit, trig_cur, trig_old, bit_ok;
    logic            wr_en, xfer, done_nxt;

    assign state = st;
    assign busy  = (st != ST_IDLE);
    assign xfer  = out_valid && out_ready;

    scope_rate_div #(.DIV_W(DIV_W)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (arm),
        .en     (st == ST_WAIT_TRIG || st == ST_CAPTURE),
        .div    (cfg_div),
        .strobe (strobe)
    );

    // Trigger bits beyond the bus width never fire.
    assign bit_ok = (int'(cfg_trig_bit) < DW);

    always_comb begin
        trig_cur = 1'b0;
        trig_old = 1'b0;
        if (bit_ok) begin
            trig_cur = sample_in[cfg_trig_bit];
            trig_old = prev[cfg_trig_bit];
        end
    end

    assign trig_hit = strobe && prev_vld && bit_ok &&
                      (cfg_trig_fall ? (trig_old && !trig_cur) : (!trig_old && trig_cur));

    always_comb begin
        st_nxt   = st;
        done_nxt = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = wptr;
        case (st)
            ST_WAIT_TRIG: begin
                if (trig_hit) begin
                    st_nxt  = ST_CAPTURE;
                    wr_en   = 1'b1;
                    wr_addr = '0;
                end
            end
            ST_CAPTURE: begin
                if (strobe) begin
                    wr_en = 1'b1;
                    if (wptr == LAST) st_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer && rptr == LAST) begin
                    st_nxt   = ST_IDLE;
                    done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
        // A restart overrides everything, including the final-transfer done pulse.
        if (arm) begin
            st_nxt   = cfg_trig_en ? ST_WAIT_TRIG : ST_CAPTURE;
            done_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[wr_addr] <= sample_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            wptr      <= '0;
            rptr      <= '0;
            prev      <= '0;
            prev_vld  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            st   <= st_nxt;
            done <= done_nxt;
            if (arm) begin
                wptr      <= '0;
                rptr      <= '0;
                prev      <= '0;
                prev_vld  <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                case (st)
                    ST_WAIT_TRIG: begin
                        if (strobe) begin
                            prev     <= sample_in;
                            prev_vld <= 1'b1;
                            if (trig_hit) wptr <= AW'(1);
                        end
                    end
                    ST_CAPTURE: begin
                        if (strobe) wptr <= wptr + AW'(1);
                    end
                    ST_DRAIN: begin
                        if (!out_valid) begin
                            out_valid <= 1'b1;
                            out_data  <= buf_mem[rptr];
                        end else if (xfer) begin
                            if (rptr == LAST) begin
                                out_valid <= 1'b0;
                                rptr      <= '0;
                            end else begin
                                rptr     <= rptr + AW'(1);
                                out_data <= buf_mem[rptr + AW'(1)];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scope_sampler.sv
// Randomized bench for scope_sampler with a queue-based reference model and per-cycle compare.
module tb_scope_sampler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  sample_in = '0;
    logic [15:0] cfg_div = '0;
    logic        cfg_trig_en = 1'b0;
    logic        cfg_trig_fall = 1'b0;
    logic [2:0]  cfg_trig_bit = '0;
    logic        arm = 1'b0;
    logic        out_valid;
    logic [5:0]  out_data;
    logic        out_ready = 1'b1;
    logic        busy;
    logic [1:0]  state;
    logic        done;

    scope_sampler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .cfg_div      (cfg_div),
        .cfg_trig_en  (cfg_trig_en),
        .cfg_trig_fall(cfg_trig_fall),
        .cfg_trig_bit (cfg_trig_bit),
        .arm          (arm),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy),
        .state        (state),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    logic [5:0] xlog[$];
    logic [5:0] exp_q[$];

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: what has been captured, what is left to deliver.
    int         m_state = 0;
    logic [15:0] m_cnt = '0;
    logic [5:0] m_prev = '0;
    logic [5:0] m_od = '0;
    bit         m_pv = 0, m_ov = 0, m_done = 0;
    logic [5:0] m_cap[$];
    logic [5:0] m_dq[$];

    always @(posedge clk) begin
        bit strobe, hit;
        int b;
        if (!rst_n) begin
            m_state = 0; m_cnt = '0; m_prev = '0; m_od = '0;
            m_pv = 0; m_ov = 0; m_done = 0;
            m_cap.delete(); m_dq.delete();
        end else begin
            m_done = 0;
            strobe = (m_state == 1 || m_state == 2) && !arm && (m_cnt == cfg_div);
            if (arm) begin
                m_state = cfg_trig_en ? 1 : 2;
                m_cap.delete(); m_dq.delete();
                m_cnt = '0; m_pv = 0; m_prev = '0; m_ov = 0;
            end else begin
                if (m_state == 1 || m_state == 2) m_cnt = strobe ? 16'd0 : m_cnt + 16'd1;
                else m_cnt = '0;
                case (m_state)
                    1: if (strobe) begin
                        b = int'(cfg_trig_bit);
                        hit = 0;
                        if (m_pv && b < 6)
                            hit = cfg_trig_fall ? (m_prev[b] && !sample_in[b])
                                                : (!m_prev[b] && sample_in[b]);
                        m_prev = sample_in;
                        m_pv = 1;
                        if (hit) begin
                            m_cap.push_back(sample_in);
                            m_state = 2;
                        end
                    end
                    2: if (strobe) begin
                        m_cap.push_back(sample_in);
                        if (m_cap.size() == 64) begin
                            m_state = 3;
                            m_dq = m_cap;
                        end
                    end
                    3: begin
                        if (!m_ov) begin
                            m_ov = 1;
                            m_od = m_dq[0];
                        end else if (out_ready) begin
                            void'(m_dq.pop_front());
                            if (m_dq.size() == 0) begin
                                m_ov = 0; m_state = 0; m_done = 1;
                            end else begin
                                m_od = m_dq[0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) xlog.push_back(out_data);
        if (done) n_done++;
        chk("state", int'(state), m_state);
        chk("out_valid", int'(out_valid), int'(m_ov));
        chk("out_data", int'(out_data), int'(m_od));
        chk("done", int'(done), int'(m_done));
        chk("busy", int'(busy), int'(m_state != 0));
    end

    bit cnt_mode = 0, rnd_mode = 0;
    int rdy_mode = 0;
    int pat_i = 0;

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (cnt_mode) sample_in = sample_in + 6'd1;
            else if (rnd_mode) sample_in = 6'($urandom);
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom);
                default: begin
                    out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
                    pat_i++;
                end
            endcase
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic wait_state(int st, int budget, string name);
        int k = 0;
        while (int'(state) != st && k < budget) begin
            tick(1);
            k++;
        end
        chk(name, int'(state), st);
    endtask

    task automatic check_log(string name);
        int bad = 0;
        chk({name, "_count"}, xlog.size(), 64);
        foreach (xlog[i]) if (i >= exp_q.size() || xlog[i] != exp_q[i]) bad++;
        chk({name, "_data_errors"}, bad, 0);
    endtask

    initial begin
        int k, bad;
        tick(2);
        rst_n = 1'b1;
        chk("rst_state", int'(state), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);

        // Immediate capture of a per-cycle counter.
        xlog.delete(); n_done = 0;
        do_arm();
        sample_in = 6'd0; cnt_mode = 1;
        wait_state(3, 200, "t1_enter_drain");
        wait_state(0, 200, "t1_idle");
        tick(2);
        chk("t1_count", xlog.size(), 64);
        bad = 0;
        foreach (xlog[i]) if (int'(xlog[i]) != i) bad++;
        chk("t1_seq_errors", bad, 0);
        chk("t1_done_pulses", n_done, 1);

        // Divider of 4, random backpressure.
        cfg_div = 16'd3; rdy_mode = 1; xlog.delete();
        do_arm();
        k = 0;
        while (state != 2'd3 && k < 400) begin tick(1); k++; end
        chk("t2_capture_cycles", k, 256);
        wait_state(0, 400, "t2_idle");
        tick(2);
        chk("t2_count", xlog.size(), 64);
        bad = 0;
        for (int i = 1; i < xlog.size(); i++) if (6'(xlog[i] - xlog[i-1]) != 6'd4) bad++;
        chk("t2_step_errors", bad, 0);

        // Rising trigger on bit 2.
        cnt_mode = 0; rdy_mode = 0; cfg_div = '0;
        cfg_trig_en = 1; cfg_trig_bit = 3'd2; cfg_trig_fall = 0;
        sample_in = 6'd0; xlog.delete();
        do_arm();
        tick(10);
        chk("t3_waiting", int'(state), 1);
        sample_in = 6'h04;
        tick(1);
        chk("t3_triggered", int'(state), 2);
        rnd_mode = 1;
        wait_state(0, 400, "t3_idle");
        tick(2);
        chk("t3_entry0", xlog.size() > 0 ? int'(xlog[0]) : -1, 4);

        // Held high level never gives a rising edge; bit 7 never triggers.
        rnd_mode = 0; sample_in = 6'h04;
        do_arm();
        tick(40);
        chk("t3_held_no_trig", int'(state), 1);
        cfg_trig_bit = 3'd7; rnd_mode = 1;
        tick(40);
        chk("t3_bit7_no_trig", int'(state), 1);

        // Random falling trigger with divider and random ready.
        cfg_trig_bit = 3'($urandom_range(0, 5)); cfg_trig_fall = 1; cfg_div = 16'd1;
        rdy_mode = 1; xlog.delete();
        do_arm();
        wait_state(3, 2000, "t3f_drain");
        exp_q = m_cap;
        wait_state(0, 600, "t3f_idle");
        tick(2);
        check_log("t3f");

        // Backpressure pattern 1,0,0,1.
        cfg_trig_en = 0; cfg_div = '0; rdy_mode = 2; pat_i = 0; xlog.delete();
        do_arm();
        wait_state(3, 200, "t4_drain");
        exp_q = m_cap;
        wait_state(0, 400, "t4_idle");
        tick(2);
        check_log("t4");

        // Abort in CAPTURE at sample 30.
        rdy_mode = 0; rnd_mode = 0; cnt_mode = 1;
        do_arm();
        sample_in = 6'd0;
        tick(30);
        cnt_mode = 0; rnd_mode = 1; xlog.delete();
        do_arm();
        wait_state(3, 200, "t5_drain");
        exp_q = m_cap;
        wait_state(0, 200, "t5_idle");
        tick(2);
        check_log("t5");

        // Abort in DRAIN while out_valid is high.
        do_arm();
        wait_state(3, 200, "t5b_drain");
        tick(3);
        chk("t5b_valid_before", int'(out_valid), 1);
        n_done = 0;
        do_arm();
        chk("t5b_valid_dropped", int'(out_valid), 0);
        chk("t5b_restart_state", int'(state), 2);
        tick(1);
        chk("t5b_no_done", n_done, 0);

        // Arm coincident with the final transfer.
        xlog.delete();
        wait_state(3, 200, "t5c_drain");
        k = 0;
        while (!(m_ov && m_dq.size() == 1) && k < 200) begin tick(1); k++; end
        chk("t5c_reached_last", int'(out_valid), 1);
        n_done = 0;
        do_arm();
        tick(1);
        chk("t5c_no_done", n_done, 0);
        chk("t5c_last_delivered", xlog.size(), 64);
        chk("t5c_restart_state", int'(state), 2);

        // Synchronous reset mid-drain, then a normal capture.
        wait_state(3, 200, "t6_drain");
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("t6_state", int'(state), 0);
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_out_data", int'(out_data), 0);
        chk("t6_done", int'(done), 0);
        xlog.delete(); n_done = 0;
        do_arm();
        wait_state(3, 200, "t6_drain2");
        exp_q = m_cap;
        wait_state(0, 200, "t6_idle");
        tick(2);
        check_log("t6");
        chk("t6_done_pulses", n_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
